// File: rtl/regbank_fwd_param.sv
// Parametrised operand register bank between decode and execute.
// Two registered read ports with write-through, one write port,
// EX/DM/WB forwarding muxes, immediate select on B, and a busy-bit
// scoreboard that reports RAW hazards on the current read addresses.
// Optional build macro: REGBANK_ZERO_REG_EN (register 0 hardwired to zero).
module regbank_fwd_param #(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned ADDR_W = 5,
  parameter int unsigned DEPTH  = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [ADDR_W-1:0] rd_addr_a,
  input  logic [ADDR_W-1:0] rd_addr_b,
  input  logic              rd_en,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic [DATA_W-1:0] fwd_ex,
  input  logic [DATA_W-1:0] fwd_dm,
  input  logic [DATA_W-1:0] fwd_wb,
  input  logic [1:0]        sel_a,
  input  logic [1:0]        sel_b,
  input  logic [DATA_W-1:0] imm,
  input  logic              imm_sel,
  input  logic              sb_set,
  input  logic [ADDR_W-1:0] sb_addr,
  output logic [DATA_W-1:0] A,
  output logic [DATA_W-1:0] B,
  output logic              hazard_a,
  output logic              hazard_b
);

  localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W+1)'(DEPTH);

`ifdef REGBANK_ZERO_REG_EN
  localparam bit ZERO_REG = 1'b1;
`else
  localparam bit ZERO_REG = 1'b0;
`endif

  logic [DATA_W-1:0] mem [DEPTH];
  logic [DATA_W-1:0] ar;
  logic [DATA_W-1:0] br;
  logic [DEPTH-1:0]  busy;
  logic [DEPTH-1:0]  busy_nxt;

  logic              wr_ok;
  logic              sb_ok;
  logic              rd_ok_a;
  logic              rd_ok_b;
  logic [DATA_W-1:0] rd_data_a;
  logic [DATA_W-1:0] rd_data_b;
  logic [DATA_W-1:0] bi;

  // Address is backed by real storage (in range and not the hardwired zero register)
  function automatic logic addr_live(input logic [ADDR_W-1:0] addr);
    return ({1'b0, addr} < DEPTH_L) && !(ZERO_REG && (addr == '0));
  endfunction

  // Qualify write, reservation and read addresses
  always_comb begin
    wr_ok   = wr_en && addr_live(wr_addr);
    sb_ok   = sb_set && addr_live(sb_addr);
    rd_ok_a = addr_live(rd_addr_a);
    rd_ok_b = addr_live(rd_addr_b);
  end

  // Read data with same-edge write-through; dead addresses read as zero
  always_comb begin
    rd_data_a = '0;
    rd_data_b = '0;
    if (rd_ok_a) begin
      rd_data_a = (wr_ok && (wr_addr == rd_addr_a)) ? wr_data : mem[rd_addr_a];
    end
    if (rd_ok_b) begin
      rd_data_b = (wr_ok && (wr_addr == rd_addr_b)) ? wr_data : mem[rd_addr_b];
    end
  end

  // Register storage
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else if (wr_ok) begin
      mem[wr_addr] <= wr_data;
    end
  end

  // Read latches; rd_en low holds them for a stall
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ar <= '0;
      br <= '0;
    end else if (rd_en) begin
      ar <= rd_data_a;
      br <= rd_data_b;
    end
  end

  // Scoreboard update: a write retires the producer, a new reservation wins
  always_comb begin
    busy_nxt = busy;
    if (wr_ok) begin
      busy_nxt[wr_addr] = 1'b0;
    end
    if (sb_ok) begin
      busy_nxt[sb_addr] = 1'b1;
    end
  end

  // Scoreboard state
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy <= '0;
    end else begin
      busy <= busy_nxt;
    end
  end

  // Hazard flags from the current scoreboard
  always_comb begin
    hazard_a = rd_ok_a ? busy[rd_addr_a] : 1'b0;
    hazard_b = rd_ok_b ? busy[rd_addr_b] : 1'b0;
  end

  // Operand forwarding muxes and immediate select
  always_comb begin
    A  = ar;
    bi = br;
    case (sel_a)
      2'd1:    A = fwd_ex;
      2'd2:    A = fwd_dm;
      2'd3:    A = fwd_wb;
      default: A = ar;
    endcase
    case (sel_b)
      2'd1:    bi = fwd_ex;
      2'd2:    bi = fwd_dm;
      2'd3:    bi = fwd_wb;
      default: bi = br;
    endcase
    B = imm_sel ? imm : bi;
  end

endmodule

// File: tb/tb_regbank_fwd_param.sv
// Directed, table-driven bench for regbank_fwd_param (DEPTH reduced to 24
// so out-of-range addresses are reachable with a 5-bit address).
module tb_regbank_fwd_param;

  localparam int unsigned DATA_W = 8;
  localparam int unsigned ADDR_W = 5;
  localparam int unsigned DEPTH  = 24;

  logic              clk;
  logic              rst_n;
  logic [ADDR_W-1:0] rd_addr_a;
  logic [ADDR_W-1:0] rd_addr_b;
  logic              rd_en;
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [DATA_W-1:0] wr_data;
  logic [DATA_W-1:0] fwd_ex;
  logic [DATA_W-1:0] fwd_dm;
  logic [DATA_W-1:0] fwd_wb;
  logic [1:0]        sel_a;
  logic [1:0]        sel_b;
  logic [DATA_W-1:0] imm;
  logic              imm_sel;
  logic              sb_set;
  logic [ADDR_W-1:0] sb_addr;
  logic [DATA_W-1:0] A;
  logic [DATA_W-1:0] B;
  logic              hazard_a;
  logic              hazard_b;

  regbank_fwd_param #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n),
    .rd_addr_a(rd_addr_a), .rd_addr_b(rd_addr_b), .rd_en(rd_en),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .fwd_ex(fwd_ex), .fwd_dm(fwd_dm), .fwd_wb(fwd_wb),
    .sel_a(sel_a), .sel_b(sel_b), .imm(imm), .imm_sel(imm_sel),
    .sb_set(sb_set), .sb_addr(sb_addr),
    .A(A), .B(B), .hazard_a(hazard_a), .hazard_b(hazard_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic              rd_en;
    logic              wr_en;
    logic [ADDR_W-1:0] wa;
    logic [DATA_W-1:0] wd;
    logic [ADDR_W-1:0] ra;
    logic [ADDR_W-1:0] rb;
    logic [1:0]        sa;
    logic [1:0]        sb;
    logic              isel;
    logic [DATA_W-1:0] imm;
    logic              sbs;
    logic [ADDR_W-1:0] sba;
    logic [DATA_W-1:0] ea;
    logic [DATA_W-1:0] eb;
    logic              eha;
    logic              ehb;
  } vec_t;

  int pass_cnt = 0;
  int total_cnt = 0;
  vec_t vecs[19];
  vec_t v;

  function automatic vec_t mk(
    input logic re, input logic we, input int wa, input int wd,
    input int ra, input int rb, input int sa, input int sb,
    input logic isel, input int im, input logic sbs, input int sba,
    input int ea, input int eb, input logic eha, input logic ehb);
    vec_t r;
    r.rd_en = re;  r.wr_en = we;
    r.wa = ADDR_W'(wa); r.wd = DATA_W'(wd);
    r.ra = ADDR_W'(ra); r.rb = ADDR_W'(rb);
    r.sa = 2'(sa); r.sb = 2'(sb);
    r.isel = isel; r.imm = DATA_W'(im);
    r.sbs = sbs; r.sba = ADDR_W'(sba);
    r.ea = DATA_W'(ea); r.eb = DATA_W'(eb);
    r.eha = eha; r.ehb = ehb;
    return r;
  endfunction

  task automatic check8(input string name, input logic [DATA_W-1:0] act, input logic [DATA_W-1:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got 0x%02h expected 0x%02h", name, act, exp);
  endtask

  task automatic check1(input string name, input logic act, input logic exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %b expected %b", name, act, exp);
  endtask

  task automatic drive(input vec_t x);
    rd_en = x.rd_en; wr_en = x.wr_en; wr_addr = x.wa; wr_data = x.wd;
    rd_addr_a = x.ra; rd_addr_b = x.rb; sel_a = x.sa; sel_b = x.sb;
    imm_sel = x.isel; imm = x.imm; sb_set = x.sbs; sb_addr = x.sba;
  endtask

  // Drive on the falling edge, let one rising edge pass, compare 1 ns later
  task automatic apply(input string tag, input vec_t x);
    @(negedge clk);
    drive(x);
    @(posedge clk);
    #1;
    check8({tag, "_A"}, A, x.ea);
    check8({tag, "_B"}, B, x.eb);
    check1({tag, "_hza"}, hazard_a, x.eha);
    check1({tag, "_hzb"}, hazard_b, x.ehb);
  endtask

  initial begin
    logic [DATA_W-1:0] r0_exp;
    logic              r0_hz;
`ifdef REGBANK_ZERO_REG_EN
    r0_exp = 8'h00;
    r0_hz  = 1'b0;
`else
    r0_exp = 8'hFF;
    r0_hz  = 1'b1;
`endif

    //           re we wa  wd    ra  rb sa sb is imm  ss sba   A     B    ha hb
    vecs[0]  = mk(0, 1, 3, 'h5A, 3,  0, 0, 0, 0, 0,   0, 0,  'h00, 'h00, 0, 0);
    vecs[1]  = mk(1, 0, 0, 0,    3,  3, 0, 0, 0, 0,   0, 0,  'h5A, 'h5A, 0, 0);
    vecs[2]  = mk(1, 1, 7, 'hC3, 7,  7, 0, 0, 0, 0,   0, 0,  'hC3, 'hC3, 0, 0);
    vecs[3]  = mk(0, 0, 0, 0,    7,  7, 1, 2, 0, 0,   0, 0,  'h11, 'h22, 0, 0);
    vecs[4]  = mk(0, 0, 0, 0,    7,  7, 2, 3, 0, 0,   0, 0,  'h22, 'h33, 0, 0);
    vecs[5]  = mk(0, 0, 0, 0,    7,  7, 3, 0, 0, 0,   0, 0,  'h33, 'hC3, 0, 0);
    vecs[6]  = mk(0, 0, 0, 0,    7,  7, 0, 1, 1, 'h7F,0, 0,  'hC3, 'h7F, 0, 0);
    vecs[7]  = mk(0, 0, 0, 0,    7,  7, 0, 3, 1, 'h7F,0, 0,  'hC3, 'h7F, 0, 0);
    vecs[8]  = mk(0, 0, 0, 0,    4,  5, 0, 0, 0, 0,   1, 4,  'hC3, 'hC3, 1, 0);
    vecs[9]  = mk(0, 1, 4, 'h44, 4,  4, 0, 0, 0, 0,   0, 0,  'hC3, 'hC3, 0, 0);
    vecs[10] = mk(1, 1, 4, 'h45, 4,  3, 0, 0, 0, 0,   1, 4,  'h45, 'h5A, 1, 0);
    vecs[11] = mk(1, 1, 30,'hEE, 30, 3, 0, 0, 0, 0,   1, 30, 'h00, 'h5A, 0, 0);
    vecs[12] = mk(1, 1, 4, 'h46, 4,  25,0, 0, 0, 0,   0, 0,  'h46, 'h00, 0, 0);
    vecs[13] = mk(1, 1, 2, 'h20, 2,  2, 0, 0, 0, 0,   0, 0,  'h20, 'h20, 0, 0);
    vecs[14] = mk(0, 1, 2, 'h21, 2,  2, 0, 0, 0, 0,   0, 0,  'h20, 'h20, 0, 0);
    vecs[15] = mk(0, 1, 2, 'h22, 2,  2, 0, 0, 0, 0,   0, 0,  'h20, 'h20, 0, 0);
    vecs[16] = mk(0, 1, 2, 'h23, 2,  2, 0, 0, 0, 0,   0, 0,  'h20, 'h20, 0, 0);
    vecs[17] = mk(1, 0, 0, 0,    2,  2, 0, 0, 0, 0,   0, 0,  'h23, 'h23, 0, 0);
    vecs[18] = mk(0, 0, 0, 0,    3,  4, 0, 0, 0, 0,   1, 4,  'h23, 'h23, 0, 1);

    fwd_ex = 8'h11;
    fwd_dm = 8'h22;
    fwd_wb = 8'h33;
    drive(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check8("reset_A", A, 8'h00);
    check8("reset_B", B, 8'h00);
    check1("reset_hza", hazard_a, 1'b0);
    check1("reset_hzb", hazard_b, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 19; i++) begin
      apply($sformatf("v%0d", i), vecs[i]);
    end

    // Asynchronous reset in the middle of a cycle, with state populated
    @(negedge clk);
    drive(mk(0, 0, 0, 0, 3, 4, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    #1;
    check8("pre_rst_A", A, 8'h23);
    check1("pre_rst_hzb", hazard_b, 1'b1);
    #1;
    rst_n = 1'b0;
    #1;
    check8("async_rst_A", A, 8'h00);
    check8("async_rst_B", B, 8'h00);
    check1("async_rst_hza", hazard_a, 1'b0);
    check1("async_rst_hzb", hazard_b, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;

    // Storage was cleared: r3 previously held 0x5A
    apply("post_rst_rd", mk(1, 0, 0, 0, 3, 7, 0, 0, 0, 0, 0, 0, 'h00, 'h00, 0, 0));

    // Register 0: write-through, stored value, reservation
    apply("r0_wt", mk(1, 1, 0, 'hFF, 0, 0, 0, 0, 0, 0, 0, 0, r0_exp, r0_exp, 0, 0));
    apply("r0_hold", mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, r0_exp, r0_exp, 0, 0));
    v = mk(1, 0, 0, 0, 0, 3, 0, 0, 0, 0, 1, 0, r0_exp, 'h00, 0, 0);
    v.eha = r0_hz;
    apply("r0_sb", v);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

// File: doc/regbank_fwd_param.md
Name: regbank_fwd_param

Overview:
Parametrised successor of the pipeline register bank. Provides two registered read ports, one write port with write-through bypass, per-operand forwarding muxes (EX/DM/WB), immediate select on operand B, and a busy-bit scoreboard that flags RAW hazards. Sits between decode and execute; feeds the ALU operands A and B.

Parameters:
DATA_W, 8, width of each register and of all data buses
ADDR_W, 5, register address width
DEPTH, 32, number of registers; must be <= 2**ADDR_W

Ports:
clk  in  1  rising-edge clock
rst_n  in  1  asynchronous active-low reset
rd_addr_a  in  ADDR_W  source register for operand A
rd_addr_b  in  ADDR_W  source register for operand B
rd_en  in  1  capture read data this edge; 0 = hold (stall)
wr_en  in  1  write enable
wr_addr  in  ADDR_W  write destination
wr_data  in  DATA_W  write data
fwd_ex  in  DATA_W  forwarded EX result
fwd_dm  in  DATA_W  forwarded DM result
fwd_wb  in  DATA_W  forwarded WB result
sel_a  in  2  A source: 0 reg, 1 EX, 2 DM, 3 WB
sel_b  in  2  B source, same encoding
imm  in  DATA_W  immediate operand
imm_sel  in  1  1 = B driven by imm
sb_set  in  1  mark sb_addr busy (instruction issued with that destination)
sb_addr  in  ADDR_W  destination being reserved
A  out  DATA_W  operand A
B  out  DATA_W  operand B
hazard_a  out  1  rd_addr_a currently busy
hazard_b  out  1  rd_addr_b currently busy

Behaviour:
- Reset (rst_n low, async): all DEPTH registers, read latches AR/BR and busy bits cleared to 0. With sel=0 and imm_sel=0, A=B=0; hazard_a=hazard_b=0.
- Write: at posedge with wr_en=1 and wr_addr<DEPTH, mem[wr_addr]<=wr_data. wr_addr>=DEPTH: write dropped.
- Read: at posedge with rd_en=1, AR<=mem[rd_addr_a], BR<=mem[rd_addr_b]; 1-cycle latency. rd_en=0: AR/BR hold.
- Write-through: same-edge write and read to same in-range address -> latch captures wr_data, not old contents. Both ports may hit simultaneously.
- rd_addr>=DEPTH: latch captures 0.
- Operand muxes (combinational): A = sel_a 0:AR, 1:fwd_ex, 2:fwd_dm, 3:fwd_wb. BI same with sel_b/BR. B = imm_sel ? imm : BI.
- Scoreboard: busy[DEPTH] bits. wr_en to addr clears busy[addr]; sb_set sets busy[sb_addr]. Same edge, same address: set wins (new producer). Out-of-range sb_addr ignored.
- hazard_a = busy[rd_addr_a] from current state (combinational, pre-edge); 0 for out-of-range. Same for hazard_b. Block never stalls itself; controller drives rd_en/sel.
- Reset mid-operation: all state cleared immediately; first post-reset edge behaves as from power-up.

Optional Feature:
Macro REGBANK_ZERO_REG_EN. Defined: register 0 hardwired to 0; writes to address 0 dropped, reads of 0 (including write-through) return 0, busy[0] never set, hazard on address 0 always 0. Undefined: register 0 ordinary storage.

Test Plan:
- Reset then write 0x5A to r3, next edge rd_addr_a=3, rd_en=1, sel_a=0 -> A=0x5A one cycle after read edge.
- Same edge wr_en r7=0xC3, rd_addr_a=rd_addr_b=7 -> A=B=0xC3 after edge (write-through both ports).
- sel_a=1..3 with fwd_ex=0x11, fwd_dm=0x22, fwd_wb=0x33 -> A=0x11/0x22/0x33; imm_sel=1, imm=0x7F -> B=0x7F regardless of sel_b.
- sb_set r4 -> hazard_a=1 for rd_addr_a=4; write r4 -> hazard_a=0 next cycle; set+write r4 same edge -> stays 1.
- rd_en=0 for 3 cycles while r2 rewritten -> A holds old value; rd_en=1 -> new value.
- Assert rst_n low mid-sequence -> A=B=0, hazards 0 asynchronously; with REGBANK_ZERO_REG_EN write 0xFF to r0 -> read returns 0x00.
